// File: rtl/bram_arbiter.sv
// bram_arbiter: two-requester round-robin front end for a single-clock byte-masked BRAM.
// Grants at most one access per cycle. Read data comes back one cycle after the handshake.
// Optional feature macro BRAM_ARB_CLEAR_EN: when defined, the RAM is zero-filled after
// reset before any request is accepted. When undefined, the arbiter starts directly in RUN.
module bram_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MASK_W = DATA_W / 8
) (
    input  logic              clock,
    input  logic              rst_n,
    // requester 0
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [MASK_W-1:0] req0_wmask,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_rdata,
    // requester 1
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic [MASK_W-1:0] req1_wmask,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_rdata,
    // RAM side
    output logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic [MASK_W-1:0] wmask,
    output logic              wren,
    input  logic [DATA_W-1:0] rdata,
    output logic              init_done
);

    logic              last;      // index of the most recently granted requester
    logic              rd_pend;   // a read was granted last cycle
    logic              rd_owner;  // requester that owns the pending read
    logic              run;
    logic              grant0;
    logic              grant1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [MASK_W-1:0] sel_wmask;

`ifdef BRAM_ARB_CLEAR_EN
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_nxt;

    // State register and clear-sweep address counter
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    assign run = (state == ST_RUN);
`else
    assign run = 1'b1;
`endif

    // Arbitration, RAM port drive and next-state; everything is held at 0 while in reset
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        raddr      = '0;
        waddr      = '0;
        wdata      = '0;
        wmask      = '0;
        wren       = 1'b0;
        grant0     = 1'b0;
        grant1     = 1'b0;
        sel_we     = 1'b0;
        sel_addr   = '0;
        sel_wdata  = '0;
        sel_wmask  = '0;
`ifdef BRAM_ARB_CLEAR_EN
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;

        if (rst_n && !run) begin
            waddr       = clr_cnt;
            wdata       = '0;
            wmask       = '1;
            wren        = 1'b1;
            clr_cnt_nxt = clr_cnt + ADDR_W'(1);
            if (clr_cnt == '1) begin
                state_nxt = ST_RUN;
            end
        end
`endif
        if (rst_n && run) begin
            // On contention the requester that was not granted last wins
            grant0     = req0_valid & (~req1_valid | last);
            grant1     = req1_valid & (~req0_valid | ~last);
            req0_ready = grant0;
            req1_ready = grant1;

            sel_we    = grant1 ? req1_we    : req0_we;
            sel_addr  = grant1 ? req1_addr  : req0_addr;
            sel_wdata = grant1 ? req1_wdata : req0_wdata;
            sel_wmask = grant1 ? req1_wmask : req0_wmask;

            if (grant0 || grant1) begin
                if (sel_we) begin
                    waddr = sel_addr;
                    wdata = sel_wdata;
                    wmask = sel_wmask;
                    wren  = 1'b1;
                end else begin
                    raddr = sel_addr;
                end
            end
        end
    end

    // Round-robin pointer and read-response tracking
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            last     <= 1'b1;
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            rd_pend  <= (grant0 & ~req0_we) | (grant1 & ~req1_we);
            rd_owner <= grant1;
            if (grant0) begin
                last <= 1'b0;
            end else if (grant1) begin
                last <= 1'b1;
            end
        end
    end

    assign resp0_valid = rd_pend & ~rd_owner;
    assign resp1_valid = rd_pend & rd_owner;
    assign resp0_rdata = rdata;
    assign resp1_rdata = rdata;
    assign init_done   = rst_n & run;

endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: scoreboard bench for bram_arbiter with a behavioural 256x32 masked RAM.
// Builds with or without BRAM_ARB_CLEAR_EN; expectations follow the chosen configuration.
module tb_bram_arbiter;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_we;
    logic [7:0]  req0_addr;
    logic [31:0] req0_wdata;
    logic [3:0]  req0_wmask;
    logic        resp0_valid;
    logic [31:0] resp0_rdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [7:0]  req1_addr;
    logic [31:0] req1_wdata;
    logic [3:0]  req1_wmask;
    logic        resp1_valid;
    logic [31:0] resp1_rdata;
    logic [7:0]  raddr, waddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wren;
    logic [31:0] rdata;
    logic        init_done;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  cyc      = 0;

    bram_arbiter dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_wmask (req0_wmask),
        .resp0_valid(resp0_valid),
        .resp0_rdata(resp0_rdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_wmask (req1_wmask),
        .resp1_valid(resp1_valid),
        .resp1_rdata(resp1_rdata),
        .raddr      (raddr),
        .waddr      (waddr),
        .wdata      (wdata),
        .wmask      (wmask),
        .wren       (wren),
        .rdata      (rdata),
        .init_done  (init_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural RAM: preloaded with a non-zero pattern, byte-masked write, registered read
    logic [31:0] mem [256];
    logic        filled = 1'b0;
    always @(posedge clock) begin
        if (!filled) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
            filled <= 1'b1;
        end else if (wren) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[raddr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Response monitor: every response must match the oldest expectation, due this cycle
    always @(negedge clock) begin : mon
        sb_t e;
        if (resp0_valid && resp1_valid) begin
            check("resp_both", 64'(1), 64'(0));
        end else if (resp0_valid || resp1_valid) begin
            if (sb_q.size() == 0 || sb_q[0].due != cyc) begin
                check("resp_unexpected", 64'({resp1_valid, resp0_valid}), 64'(0));
            end else begin
                e = sb_q.pop_front();
                check("resp_port", 64'(resp1_valid), 64'(e.port));
                check("resp_data", 64'(resp1_valid ? resp1_rdata : resp0_rdata), 64'(e.data));
            end
        end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            check("resp_missing", 64'(0), 64'(1));
        end
    end

    // One access from a requester; reads push their expected data to the scoreboard
    task automatic access(input int port, input logic we, input logic [7:0] addr,
                          input logic [31:0] wd, input logic [3:0] wm, input logic [31:0] exp);
        logic got;
        got = 1'b0;
        if (port == 0) begin
            req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wd; req0_wmask = wm;
        end else begin
            req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wd; req1_wmask = wm;
        end
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clock);
            got = (port == 0) ? req0_ready : req1_ready;
        end
        if (!got) check("access_timeout", 64'(0), 64'(1));
        else if (!we) sb_q.push_back('{port: port, data: exp, due: cyc + 1});
        @(posedge clock); #1;
        if (port == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    task automatic wait_init();
        for (int n = 0; n < 400 && !init_done; n++) @(negedge clock);
        check("init_done_wait", 64'(init_done), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_7f;
        logic [31:0] exp_10_after_rst;
        logic        got;
`ifdef BRAM_ARB_CLEAR_EN
        exp_7f           = 32'h0;
        exp_10_after_rst = 32'h0;
`else
        exp_7f           = 32'hA500_007F;
        exp_10_after_rst = 32'h01BB_03DD;
`endif
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h00; req0_wdata = '0; req0_wmask = '0;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h00; req1_wdata = '0; req1_wmask = '0;

        // Outputs held at zero during reset even with both requesters valid
        repeat (3) begin
            @(negedge clock);
            check("reset_outputs", 64'({req0_ready, req1_ready, wren, raddr, waddr, wdata,
                                        wmask, init_done, resp0_valid, resp1_valid}), 64'(0));
        end

`ifdef BRAM_ARB_CLEAR_EN
        @(posedge clock); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            check("clear_sweep", 64'({req0_ready, req1_ready, wren, waddr, wdata, wmask, init_done}),
                  64'({1'b0, 1'b0, 1'b1, 8'(i), 32'h0, 4'hF, 1'b0}));
        end
        // First RUN cycle: both still valid, requester 0 wins the first contention
        @(negedge clock);
        check("first_run", 64'({init_done, req0_ready, req1_ready}), 64'(3'b110));
        if (req0_ready) sb_q.push_back('{port: 0, data: 32'h0, due: cyc + 1});
        @(posedge clock); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
`else
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clock); #1;
        rst_n = 1'b1;
        @(negedge clock);
        check("first_run", 64'({init_done, req0_ready, req1_ready, wren}), 64'(4'b1000));
        @(posedge clock); #1;
`endif

        access(0, 1'b0, 8'h7F, '0, '0, exp_7f);

        // Seed the contention addresses; the last write comes from requester 1
        access(0, 1'b1, 8'h01, 32'h1111_1111, 4'hF, '0);
        access(1, 1'b1, 8'h02, 32'h2222_2222, 4'hF, '0);

        // Single requester write then read-back
        access(0, 1'b1, 8'h10, 32'h0102_0304, 4'hF, '0);
        access(0, 1'b0, 8'h10, '0, '0, 32'h0102_0304);

        // Byte-masked write from requester 1
        access(1, 1'b1, 8'h10, 32'hAABB_CCDD, 4'b0101, '0);
        access(1, 1'b0, 8'h10, '0, '0, 32'h01BB_03DD);

        // Zero mask write: handshake with wren, no data change
        access(0, 1'b1, 8'h10, 32'hFFFF_FFFF, 4'b0000, '0);
        access(1, 1'b0, 8'h10, '0, '0, 32'h01BB_03DD);

        // Contention: both hold reads, grants alternate starting with requester 0
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h01;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h02;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("contend_grant", 64'({req0_ready, req1_ready}),
                  64'((i % 2 == 0) ? 2'b10 : 2'b01));
            if (req0_ready) sb_q.push_back('{port: 0, data: 32'h1111_1111, due: cyc + 1});
            if (req1_ready) sb_q.push_back('{port: 1, data: 32'h2222_2222, due: cyc + 1});
        end
        @(posedge clock); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Idle RAM port
        @(negedge clock);
        check("idle_ram", 64'({raddr, waddr, wdata, wmask, wren}), 64'(0));
        @(posedge clock); #1;

        // Reset in the cycle after a read handshake: the response must be dropped
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h10;
        got = 1'b0;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clock);
            got = req0_ready;
        end
        check("rst_read_grant", 64'(got), 64'(1));
        @(posedge clock); #1;
        rst_n = 1'b0;
        req0_valid = 1'b0;
        repeat (2) begin
            @(negedge clock);
            check("rst_mid_outputs", 64'({req0_ready, req1_ready, wren, init_done,
                                          resp0_valid, resp1_valid}), 64'(0));
        end
        @(posedge clock); #1;
        rst_n = 1'b1;
        @(negedge clock);
`ifdef BRAM_ARB_CLEAR_EN
        check("clear_restart", 64'({wren, waddr, init_done}), 64'({1'b1, 8'h00, 1'b0}));
        wait_init();
`else
        check("rerun_init", 64'({init_done, wren}), 64'(2'b10));
`endif
        @(posedge clock); #1;
        access(1, 1'b0, 8'h10, '0, '0, exp_10_after_rst);

        repeat (3) @(negedge clock);
        check("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Two-requester round-robin arbiter and post-reset initialiser for the single-clock 256 × 32 byte-masked block RAM (`bram_align2_1024_mask`). It sits between two independent masters, such as a CPU data port and a debug/DMA port, and the RAM. It grants at most one access (read or masked write) per cycle and returns read data with fixed one-cycle latency. When enabled, it zero-fills the RAM after reset before accepting any request.

## Interface
Parameters:
- `ADDR_W`, default 8: RAM word-address width; depth = 2**ADDR_W.
- `DATA_W`, default 32: word width; must be a multiple of 8.
- `MASK_W`, default DATA_W/8: byte-lane write-mask width (derived, not overridden).

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `reqN_valid`  in  1  (N = 0, 1) requester N has an access pending.
- `reqN_ready`  out  1  access accepted this cycle; handshake = valid & ready.
- `reqN_we`  in  1  1 = write, 0 = read.
- `reqN_addr`  in  ADDR_W  word address.
- `reqN_wdata`  in  DATA_W  write data.
- `reqN_wmask`  in  MASK_W  byte enables for the write (bit i covers byte i).
- `respN_valid`  out  1  one-cycle pulse; `respN_rdata` is valid.
- `respN_rdata`  out  DATA_W  read data (equal to the RAM `rdata` input).
- `raddr`, `waddr`  out  ADDR_W  RAM read/write address.
- `wdata`  out  DATA_W; `wmask`  out  MASK_W; `wren`  out  1  RAM write port.
- `rdata`  in  DATA_W  RAM read data, registered inside the RAM (1-cycle).
- `init_done`  out  1  high once the arbiter is accepting requests.

## Operation
- States: CLEAR and RUN.
  - Reset enters CLEAR if the clear feature is compiled in, otherwise RUN.
  - CLEAR→RUN occurs on the cycle after the write to address 2**ADDR_W−1.
  - RUN is terminal until reset.
- CLEAR: an ADDR_W-bit counter drives `waddr`, with `wdata`=0, `wmask`=all ones and `wren`=1. The counter increments each cycle from 0. `reqN_ready`=0 and `init_done`=0.
- RUN, arbitration (combinational from valids and the `last` pointer):
  - Only one valid: that requester is granted.
  - Both valid: the requester ≠ `last` is granted.
  - `last` updates to the granted index on every handshake.
  - `last` resets to 1, so requester 0 wins the first contention.
- Grant drives `reqN_ready`=1 for the winner only.
  - Grant is independent of the requester's own ready; requesters hold all fields stable until ready.
- Granted write: `waddr`=addr, `wdata`, `wmask` pass through, `wren`=1. No response is issued.
- Granted read: `raddr`=addr, `wren`=0. A registered `rd_owner` and `rd_pend` are set.
- Idle RAM outputs: `raddr`, `waddr`, `wdata`, `wmask` and `wren` are all 0.
- `wmask`=0 with `we`=1 is still a handshake with `wren`=1; no byte changes.

## Timing
- Handshake in cycle T. For a read, `respN_valid`=1 in cycle T+1 only, and `respN_rdata`=`rdata` in that cycle.
  - The other requester's `respN_valid` stays 0.
  - `respN_rdata` is undefined (but equals `rdata`) when not valid.
- Throughput is one access per cycle. Back-to-back reads from the same requester give back-to-back responses.
- Write at T followed by a read of the same address at T+1 returns the new data at T+2. Single-port-per-cycle granting excludes same-cycle read/write collisions.
- Reset values, and values forced for as long as `rst_n`=0:
  - `reqN_ready`=0, `respN_valid`=0, `wren`=0, `init_done`=0.
  - `raddr`, `waddr`, `wdata` and `wmask` are 0.
  - The clear counter is 0, `last`=1 and `rd_pend`=0.
- Reset mid-operation:
  - A pending read response is dropped.
  - A CLEAR sweep restarts at address 0.
  - No RAM write occurs while `rst_n`=0.
- CLEAR duration is exactly 2**ADDR_W cycles (256 at default). `init_done` rises in the first RUN cycle.

## Configuration
- `BRAM_ARB_CLEAR_EN`:
  - Defined: post-reset CLEAR sweep zero-fills every word before RUN.
  - Undefined: the CLEAR state and counter are not built. Reset goes directly to RUN, `init_done`=1 from the first cycle after reset deasserts, and RAM contents are unchanged by reset.

## Test plan
- Clear sweep (macro defined):
  - Stimulus: release reset with both valids high.
  - Required: `reqN_ready`=0 for 256 cycles and `wren`=1 with `waddr` 0..255, `wdata`=0, `wmask`=4'b1111. `init_done` rises at cycle 256, then a read of addr 0x7F returns 0.
- Single requester:
  - Stimulus: req0 writes 0x01020304 to addr 0x10 with mask 4'b1111, then reads 0x10 the next cycle.
  - Required: `resp0_valid` pulses one cycle later with rdata 0x01020304, and `resp1_valid` stays 0.
- Byte mask:
  - Stimulus: after the previous test, req1 writes 0xAABBCCDD to 0x10 with mask 4'b0101, then reads 0x10.
  - Required: rdata 0x01BB03DD.
- Contention:
  - Stimulus: both hold valid reads (addr 1 and addr 2) for 6 cycles.
  - Required: grants alternate 0,1,0,1,0,1, each response on the correct port one cycle later.
- Reset mid-read:
  - Stimulus: assert `rst_n`=0 in the cycle after a read handshake.
  - Required: no `respN_valid` pulse. With the macro defined, CLEAR restarts at `waddr`=0.
